// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: pops words from a FIFO and sends them as async serial frames
module fifo_uart_tx #(
  parameter int WIDTH = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int STOP_BITS = 1
) (
  input  logic             clk,
  input  logic             res,
  input  logic             enable,
  input  logic [WIDTH-1:0] fifo_rdata,
  input  logic             fifo_empty,
  output logic             fifo_shift_out,
  output logic             tx,
  output logic             busy
);
  localparam int CW = CLKS_PER_BIT > 1 ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BN = WIDTH > STOP_BITS ? WIDTH : STOP_BITS;
  localparam int BW = BN > 1 ? $clog2(BN) : 1;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t state, state_n;
  logic [CW-1:0] baud, baud_n;
  logic [BW-1:0] bit_cnt, bit_n;
  logic [WIDTH-1:0] shreg, shreg_n;
  logic baud_end, last_stop, tx_n;
  assign baud_end = baud == CW'(CLKS_PER_BIT - 1);
  assign last_stop = state == STOP && baud_end && bit_cnt == BW'(STOP_BITS - 1);
  assign fifo_shift_out = enable && !fifo_empty && !res && (state == IDLE || last_stop);
  // next state, counters and shift register; a pop overrides everything and restarts a frame
  always_comb begin
    state_n = state;
    baud_n = (state == IDLE || baud_end) ? '0 : baud + CW'(1);
    bit_n = bit_cnt;
    shreg_n = shreg;
    case (state)
      IDLE: state_n = IDLE;
      START: state_n = baud_end ? DATA : START;
      DATA: if (baud_end) begin
        shreg_n = shreg >> 1;
        state_n = bit_cnt == BW'(WIDTH - 1) ? STOP : DATA;
        bit_n = bit_cnt == BW'(WIDTH - 1) ? '0 : bit_cnt + BW'(1);
      end
      STOP: if (baud_end) begin
        state_n = last_stop ? IDLE : STOP;
        bit_n = last_stop ? '0 : bit_cnt + BW'(1);
      end
      default: state_n = IDLE;
    endcase
    if (fifo_shift_out) begin
      state_n = START;
      baud_n = '0;
      bit_n = '0;
      shreg_n = fifo_rdata;
    end
    tx_n = state_n == START ? 1'b0 : state_n == DATA ? shreg_n[0] : 1'b1;
  end
  // state register with registered, glitch-free tx and busy
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      state <= IDLE;
      baud <= '0;
      bit_cnt <= '0;
      shreg <= '0;
      tx <= 1'b1;
      busy <= 1'b0;
    end else begin
      state <= state_n;
      baud <= baud_n;
      bit_cnt <= bit_n;
      shreg <= shreg_n;
      tx <= tx_n;
      busy <= state_n != IDLE;
    end
  end
endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb_fifo_uart_tx: scoreboard bench with a FIFO model and a serial-line frame checker
module tb_fifo_uart_tx;
  localparam int W = 8, C = 4, F = (1 + W + 1) * C;
  logic clk = 0, res = 1, enable = 0, fifo_empty = 1, fifo_shift_out, tx, busy;
  logic [W-1:0] fifo_rdata = '0;
  logic enable2 = 0, fifo_empty2 = 1, shift2, tx2, busy2;
  logic [W-1:0] rdata2 = '0;
  int checks = 0, errors = 0, pops = 0, frames = 0, pops2 = 0;
  logic [W-1:0] fifo_q[$], exp_q[$];
  int idx, b, eb, run, max_run;
  bit in_frame = 0, prev_pop = 0, pop_ok;
  logic [W-1:0] cur, got;

  always #5 clk = ~clk;

  fifo_uart_tx #(.WIDTH(W), .CLKS_PER_BIT(C), .STOP_BITS(1)) dut (
    .clk(clk), .res(res), .enable(enable), .fifo_rdata(fifo_rdata), .fifo_empty(fifo_empty),
    .fifo_shift_out(fifo_shift_out), .tx(tx), .busy(busy));

  fifo_uart_tx #(.WIDTH(W), .CLKS_PER_BIT(C), .STOP_BITS(2)) dut2 (
    .clk(clk), .res(res), .enable(enable2), .fifo_rdata(rdata2), .fifo_empty(fifo_empty2),
    .fifo_shift_out(shift2), .tx(tx2), .busy(busy2));

  task automatic check_eq(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void refresh();
    fifo_empty = fifo_q.size() == 0;
    fifo_rdata = fifo_q.size() != 0 ? fifo_q[0] : W'($urandom);
  endfunction

  // one clock: model FIFO pops the head when the DUT strobed shift_out at this edge
  task automatic tick();
    bit p;
    @(negedge clk);
    p = fifo_shift_out;
    @(posedge clk);
    if (p && !res) begin
      exp_q.push_back(fifo_q.pop_front());
      pops++;
    end
    #1 refresh();
  endtask

  task automatic wait_done();
    int n = 0;
    tick();
    tick();
    while ((fifo_q.size() != 0 || busy) && n < 2000) begin
      tick();
      n++;
    end
    check_eq("drain_timeout", int'(n < 2000), 1);
  endtask

  task automatic wait_pop();
    int p0 = pops, n = 0;
    while (pops == p0 && n < 50) begin
      tick();
      n++;
    end
    check_eq("pop_timeout", int'(pops != p0), 1);
  endtask

  always @(posedge clk) if (shift2) pops2++;

  // monitor: checks every tx cycle of a frame against the scoreboard word and idle rules
  always @(negedge clk) begin
    if (res) begin
      check_eq("reset_tx", tx, 1);
      check_eq("reset_busy", busy, 0);
      check_eq("reset_pop", fifo_shift_out, 0);
      in_frame = 0;
      prev_pop = 0;
      run = 0;
    end else begin
      run = busy ? run + 1 : 0;
      if (run > max_run) max_run = run;
      if (!in_frame && (tx == 0 || prev_pop)) begin
        check_eq("start_after_pop", prev_pop, 1);
        check_eq("pop_to_start", tx, 0);
        check_eq("expected_word_present", exp_q.size(), 1);
        cur = exp_q.size() != 0 ? exp_q[0] : '0;
        got = '0;
        in_frame = 1;
        idx = 0;
      end
      if (in_frame) begin
        b = idx / C;
        eb = b == 0 ? 0 : b <= W ? int'(cur[b-1]) : 1;
        check_eq("tx_bit", tx, eb);
        check_eq("busy_frame", busy, 1);
        if (idx % C == C / 2 && b >= 1 && b <= W) got[b-1] = tx;
        pop_ok = idx == F - 1;
        if (idx == F - 1) begin
          in_frame = 0;
          frames++;
          if (exp_q.size() != 0) void'(exp_q.pop_front());
          check_eq("frame_word", got, cur);
        end else idx++;
      end else begin
        check_eq("idle_tx", tx, 1);
        check_eq("idle_busy", busy, 0);
        pop_ok = 1;
      end
      if (fifo_shift_out) check_eq("pop_legal", int'(pop_ok && enable && !fifo_empty), 1);
      prev_pop = fifo_shift_out;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int p, f, n;
    logic [W-1:0] w2;
    int fb[11];
    fifo_q.push_back(8'h5A);
    refresh();
    repeat (3) tick();
    res = 0;
    repeat (6) tick();
    check_eq("no_pop_disabled", pops, 0);
    fifo_q.delete();
    fifo_q.push_back(8'hA5);
    refresh();
    enable = 1;
    p = pops; f = frames;
    wait_done();
    check_eq("single_pop", pops - p, 1);
    check_eq("single_frame", frames - f, 1);
    check_eq("idle_after_busy", busy, 0);
    fifo_q.push_back(8'h00);
    fifo_q.push_back(8'hFF);
    refresh();
    p = pops; f = frames; max_run = 0;
    wait_done();
    check_eq("b2b_pops", pops - p, 2);
    check_eq("b2b_frames", frames - f, 2);
    check_eq("b2b_contiguous", max_run, 2 * F);
    p = pops;
    repeat (100) tick();
    check_eq("empty_no_pop", pops - p, 0);
    fifo_q.push_back(W'($urandom));
    fifo_q.push_back(W'($urandom));
    refresh();
    p = pops; f = frames;
    wait_pop();
    repeat (15) tick();
    enable = 0;
    repeat (60) tick();
    check_eq("disable_one_pop", pops - p, 1);
    check_eq("disable_frame_done", frames - f, 1);
    check_eq("disable_idle", busy, 0);
    enable = 1;
    #2 check_eq("reenable_pop", fifo_shift_out, 1);
    wait_done();
    check_eq("reenable_frames", frames - f, 2);
    fifo_q.push_back(8'h3C);
    fifo_q.push_back(8'hC3);
    refresh();
    f = frames;
    wait_pop();
    repeat (10) tick();
    #2 res = 1;
    #1 check_eq("async_tx", tx, 1);
    check_eq("async_busy", busy, 0);
    exp_q.delete();
    tick();
    tick();
    res = 0;
    wait_done();
    check_eq("after_reset_frame", frames - f, 1);
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0 && fifo_q.size() < 4) fifo_q.push_back(W'($urandom));
      enable = $urandom_range(0, 9) != 0;
      refresh();
      tick();
    end
    enable = 1;
    wait_done();
    check_eq("rand_drained", exp_q.size(), 0);
    check_eq("pops_equal_frames", pops, frames + 1);
    w2 = 8'h96;
    rdata2 = w2;
    fifo_empty2 = 0;
    enable2 = 1;
    n = 0;
    @(negedge clk);
    while (!shift2 && n < 5) begin
      @(negedge clk);
      n++;
    end
    check_eq("stop2_pop", shift2, 1);
    @(posedge clk);
    #1 fifo_empty2 = 1;
    enable2 = 0;
    rdata2 = 8'h00;
    n = 0;
    @(negedge clk);
    while (busy2 && n < 100) begin
      if (n % C == C / 2 && n / C < 11) fb[n / C] = tx2;
      n++;
      @(negedge clk);
    end
    check_eq("stop2_frame_len", n, (1 + W + 2) * C);
    for (int k = 0; k < 11; k++)
      check_eq("stop2_bit", fb[k], k == 0 ? 0 : k <= W ? int'((w2 >> (k - 1)) & 1) : 1);
    check_eq("stop2_pulses", pops2, 1);
    check_eq("stop2_idle_tx", tx2, 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
